ticket_bcd_counter: RTL

Three-digit BCD ticket counter for the digital ticket counter display path. It conditions the raw "issue" and "cancel" push-button inputs and maintains a saturating count from 0 to MAX_COUNT in packed BCD. Its three BCD digit outputs drive one BCD-to-7-segment decoder per digit. It also raises full/empty status and a one-cycle alarm pulse when a request is refused.

---
 rtl/ticket_bcd_counter_pkg.sv | 23 ++
 rtl/ticket_bcd_counter_if.sv | 25 ++
 rtl/ticket_bcd_counter_btn_conditioner.sv | 73 +++++++
 rtl/ticket_bcd_counter.sv | 116 +++++++++++
 4 files changed

// File: rtl/ticket_bcd_counter_pkg.sv
// Shared types and helpers for the three-digit BCD ticket counter.
package ticket_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_ZERO      = 4'd0;

    typedef struct packed {
        bcd_digit_t hund;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd3_t;

    function automatic bcd3_t to_bcd3(input int value);
        bcd3_t r;
        r.hund = bcd_digit_t'((value / 100) % 10);
        r.tens = bcd_digit_t'((value / 10) % 10);
        r.ones = bcd_digit_t'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/ticket_bcd_counter_if.sv
// Button, clear and display/status signals of the ticket counter.
interface ticket_bcd_counter_if;
    import ticket_pkg::*;

    logic       btn_inc;
    logic       btn_dec;
    logic       clr;
    bcd_digit_t bcd_ones;
    bcd_digit_t bcd_tens;
    bcd_digit_t bcd_hund;
    logic       full;
    logic       empty;
    logic       refuse;

    modport slave (
        input  btn_inc, btn_dec, clr,
        output bcd_ones, bcd_tens, bcd_hund, full, empty, refuse
    );

    modport master (
        output btn_inc, btn_dec, clr,
        input  bcd_ones, bcd_tens, bcd_hund, full, empty, refuse
    );

endinterface

// File: rtl/ticket_bcd_counter_btn_conditioner.sv
// Raw button -> 2-flop synchronizer -> optional debounce -> one-cycle press pulse.
// Debounce stage is built only when TICKET_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

`ifdef TICKET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Counter measures how long the synchronized input has disagreed with the
    // accepted level; any agreement restarts the measurement.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press = level & ~prev_q;

endmodule

// File: rtl/ticket_bcd_counter.sv
// Saturating 0..MAX_COUNT packed-BCD ticket counter with full/empty flags and refuse pulse.
// Optional button debounce selected by TICKET_DEBOUNCE_EN.
module ticket_bcd_counter
    import ticket_pkg::*;
#(
    parameter int MAX_COUNT       = 999,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ticket_bcd_counter_if.slave  bus
);

    localparam bcd3_t MAX_BCD = to_bcd3(MAX_COUNT);

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       inc_pulse;
    logic       dec_pulse;

    assign btn_raw = {bus.btn_dec, bus.btn_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_conditioner #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_raw (btn_raw[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    assign inc_pulse = press[0];
    assign dec_pulse = press[1];

    function automatic bcd3_t bcd_inc(input bcd3_t v);
        bcd3_t r;
        r = v;
        if (v.ones == BCD_MAX_DIGIT) begin
            r.ones = BCD_ZERO;
            if (v.tens == BCD_MAX_DIGIT) begin
                r.tens = BCD_ZERO;
                r.hund = v.hund + 4'd1;
            end else begin
                r.tens = v.tens + 4'd1;
            end
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd3_t bcd_dec(input bcd3_t v);
        bcd3_t r;
        r = v;
        if (v.ones == BCD_ZERO) begin
            r.ones = BCD_MAX_DIGIT;
            if (v.tens == BCD_ZERO) begin
                r.tens = BCD_MAX_DIGIT;
                r.hund = v.hund - 4'd1;
            end else begin
                r.tens = v.tens - 4'd1;
            end
        end else begin
            r.ones = v.ones - 4'd1;
        end
        return r;
    endfunction

    bcd3_t cnt_q, cnt_d;
    logic  refuse_q, refuse_d;
    logic  full;
    logic  empty;

    assign full  = (cnt_q == MAX_BCD);
    assign empty = (cnt_q == '0);

    // Saturation guards keep the hundreds digit inside 0..9 for any legal MAX_COUNT.
    always_comb begin
        cnt_d    = cnt_q;
        refuse_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (inc_pulse && dec_pulse) begin
            cnt_d = cnt_q;
        end else if (inc_pulse) begin
            if (full) refuse_d = 1'b1;
            else      cnt_d    = bcd_inc(cnt_q);
        end else if (dec_pulse) begin
            if (empty) refuse_d = 1'b1;
            else       cnt_d    = bcd_dec(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            refuse_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            refuse_q <= refuse_d;
        end
    end

    assign bus.bcd_ones = cnt_q.ones;
    assign bus.bcd_tens = cnt_q.tens;
    assign bus.bcd_hund = cnt_q.hund;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.refuse   = refuse_q;

endmodule
